// File: rtl/cpu_io_pkg.sv
// Shared types and widths for the CPU I/O bridge.
package cpu_io_pkg;

    localparam int WORD_W = 16;
    localparam int NIB_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/cpu_io_fifo.sv
// Capture FIFO for CPU output words. The caller gates push so that it never
// overflows and gates pop so that it never underflows. out data reads 0 when empty.
module cpu_io_fifo
    import cpu_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] data
);

    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    // Storage array: data only, no reset needed since empty masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cpu_io_bridge.sv
// Host <-> CPU I/O bridge: paces host nibbles onto the CPU input port and
// captures every change of the CPU output word into a FIFO for the host.
// Optional feature macro: DROP_COUNT_EN adds the saturating drop_count port.
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_data,
    output logic              in_ready,
    output logic [NIB_W-1:0]  cpu_inr,
    input  logic [WORD_W-1:0] cpu_outvalue,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready
`ifdef DROP_COUNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        hold_cnt;
    logic [3:0]        hold_nxt;
    logic [NIB_W-1:0]  inr_nxt;
    logic [WORD_W-1:0] prev;
    logic              capture;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // Input FSM state, hold counter and sticky CPU input register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            cpu_inr  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            cpu_inr  <= inr_nxt;
        end
    end

    // Accept a nibble in IDLE, then hold it for HOLD_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        inr_nxt   = cpu_inr;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    inr_nxt   = in_data;
                    hold_nxt  = 4'(HOLD_CYCLES - 1);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Previous CPU output word, for change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= cpu_outvalue;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still take a capture.
    assign capture   = (cpu_outvalue != prev);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = capture & (~full | pop);

    cpu_io_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (cpu_outvalue),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .data  (out_data)
    );

`ifdef DROP_COUNT_EN
    logic drop;
    assign drop = capture & full & ~pop;

    // Saturating count of captures lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Testbench for cpu_io_bridge: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_cpu_io_bridge;

    localparam int DEPTH       = 4;
    localparam int HOLD_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_ready;
    logic [3:0]  cpu_inr;
    logic [15:0] cpu_outvalue = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
`ifdef DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int          busy;
    logic [3:0]  inr_m;
    logic [15:0] prev_m;
    logic [15:0] q[$];
    int          drops;

    always #5 clk = ~clk;

    cpu_io_bridge #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .cpu_inr      (cpu_inr),
        .cpu_outvalue (cpu_outvalue),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
`ifdef DROP_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy   = 0;
        inr_m  = '0;
        prev_m = '0;
        q.delete();
        drops  = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(busy == 0));
        chk({tag, "_cpu_inr"}, 32'(cpu_inr), 32'(inr_m));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "_out_data"}, 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
`ifdef DROP_COUNT_EN
        chk({tag, "_drop_count"}, 32'(drop_count), 32'(drops));
`endif
    endtask

    // Advance one clock: update the model from the inputs present before the
    // edge, then compare DUT outputs just after the edge.
    task automatic step(input string tag);
        bit pop_m;
        bit chg;
        if (busy == 0) begin
            if (in_valid) begin
                inr_m = in_data;
                busy  = HOLD_CYCLES;
            end
        end else begin
            busy--;
        end
        chg   = (cpu_outvalue != prev_m);
        pop_m = (q.size() != 0) && out_ready;
        if (pop_m) void'(q.pop_front());
        if (chg) begin
            if (q.size() < DEPTH) q.push_back(cpu_outvalue);
            else if (drops < 255) drops++;
        end
        prev_m = cpu_outvalue;
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Assert reset between edges and check that it takes effect without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        compare_all("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] nibs [3];
        int idx;
        bit was_ready;
        logic [3:0] exp_inr;

        nibs[0] = 4'd5; nibs[1] = 4'd6; nibs[2] = 4'd1;
        model_reset();
        #1;
        do_reset();

        // single nibble accept and hold
        in_valid = 1'b1; in_data = 4'd5;
        step("n1");
        chk("n1_inr5", 32'(cpu_inr), 32'd5);
        chk("n1_busy_a", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step("n1b");
        chk("n1_busy_b", 32'(in_ready), 32'd0);
        step("n1c");
        chk("n1_ready", 32'(in_ready), 32'd1);
        chk("n1_sticky", 32'(cpu_inr), 32'd5);

        // back-to-back nibbles with in_valid held
        do_reset();
        idx = 0;
        for (int k = 0; k < 9; k++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? nibs[idx] : 4'd0;
            was_ready = in_ready;
            step("b2b");
            if (was_ready && idx < 3) idx++;
            exp_inr = nibs[k / 3];
            chk("b2b_inr", 32'(cpu_inr), 32'(exp_inr));
        end
        in_valid = 1'b0;

        // single capture, held value adds nothing
        do_reset();
        out_ready = 1'b0;
        cpu_outvalue = 16'h0007;
        step("cap");
        chk("cap_valid", 32'(out_valid), 32'd1);
        chk("cap_data", 32'(out_data), 32'h7);
        step("cap_hold1");
        step("cap_hold2");
        out_ready = 1'b1;
        step("cap_pop");
        chk("cap_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // fill, drop, then simultaneous push/pop at full
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            cpu_outvalue = 16'(v);
            step("fill");
        end
        chk("fill_head", 32'(out_data), 32'd1);
`ifdef DROP_COUNT_EN
        chk("fill_drop", 32'(drop_count), 32'd1);
`endif
        cpu_outvalue = 16'd9;
        out_ready = 1'b1;
        step("fullpp");
        chk("order0", 32'(out_data), 32'd2);
        step("drain1");
        chk("order1", 32'(out_data), 32'd3);
        step("drain2");
        chk("order2", 32'(out_data), 32'd4);
        step("drain3");
        chk("order3", 32'(out_data), 32'd9);
        step("drain4");
        chk("drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // reset mid-HOLD with three entries
        do_reset();
        cpu_outvalue = 16'd1; step("m1");
        cpu_outvalue = 16'd2; step("m2");
        cpu_outvalue = 16'd3; in_valid = 1'b1; in_data = 4'hA; step("m3");
        in_valid = 1'b0;
        chk("m_busy", 32'(in_ready), 32'd0);
        do_reset();
        chk("m_ready", 32'(in_ready), 32'd1);
        chk("m_inr", 32'(cpu_inr), 32'd0);
        chk("m_valid", 32'(out_valid), 32'd0);
        // nonzero output after reset release is a capture
        step("post_rst");
        chk("post_rst_cap", 32'(out_data), 32'd3);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) cpu_outvalue = 16'($urandom_range(0, 7));
            out_ready = (k % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
